trap_ctrl: RTL and testbench

- Machine-mode trap sequencer that sits directly upstream of the CSR register file and owns its single write port.
- On a synchronous exception (ecall, ebreak, illegal instruction) or an enabled external interrupt, it stalls the pipeline and writes mepc, mcause and mstatus in successive cycles, then redirects fetch to mtvec.
- On mret it restores mstatus and redirects fetch to mepc.
- When idle it passes the datapath's csrrw/csrrwi accesses straight through to the CSR file.

---
 rtl/trap_pkg.sv | 71 +++++++
 rtl/trap_ctrl_if.sv | 43 ++++
 rtl/trap_ctrl.sv | 132 +++++++++++++
 tb/tb_trap_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trap_pkg
//  Brief    : Shared constants, state encoding and request priority encoder
//             for the machine-mode trap sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package trap_pkg;

   // CSR addresses as decoded by the downstream CSR register file
   localparam logic [11:0] CSR_MSTATUS = 12'h000;
   localparam logic [11:0] CSR_MTVEC   = 12'h005;
   localparam logic [11:0] CSR_MEPC    = 12'h041;
   localparam logic [11:0] CSR_MCAUSE  = 12'h042;

   // mstatus bit positions
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // mcause values
   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;
   localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;

   // Sequencer state encoding
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_SAVE_EPC   = 3'd1;
   localparam logic [2:0] ST_SAVE_CAUSE = 3'd2;
   localparam logic [2:0] ST_SET_STATUS = 3'd3;
   localparam logic [2:0] ST_VECTOR     = 3'd4;
   localparam logic [2:0] ST_RET_STATUS = 3'd5;
   localparam logic [2:0] ST_RET_PC     = 3'd6;

   // Winning request: valid when anything is pending, is_ret for mret
   typedef struct packed {
      logic        valid;
      logic        is_ret;
      logic [31:0] cause;
   } trap_req_t;

   // Fixed priority: illegal > ebreak > ecall > irq > mret.
   // irq_en must already be qualified by the interrupt enable.
   function automatic trap_req_t trap_prio(input logic illegal,
                                           input logic ebreak,
                                           input logic ecall,
                                           input logic irq_en,
                                           input logic mret);
      trap_req_t r;
      r = '{valid: 1'b0, is_ret: 1'b0, cause: 32'd0};
      if (illegal) begin
         r.valid = 1'b1;
         r.cause = CAUSE_ILLEGAL;
      end else if (ebreak) begin
         r.valid = 1'b1;
         r.cause = CAUSE_EBREAK;
      end else if (ecall) begin
         r.valid = 1'b1;
         r.cause = CAUSE_ECALL;
      end else if (irq_en) begin
         r.valid = 1'b1;
         r.cause = CAUSE_IRQ;
      end else if (mret) begin
         r.valid  = 1'b1;
         r.is_ret = 1'b1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl_if
//  Brief    : Bundle between the pipeline/CSR file (master) and the trap
//             sequencer (slave): requests, datapath CSR port, CSR file port,
//             stall and fetch redirect.
//  Revision : 1.0  initial release
// ============================================================================
interface trap_ctrl_if #(
   parameter int XLEN = 32
);
   logic            ecall;
   logic            ebreak;
   logic            illegal;
   logic            mret;
   logic            irq;
   logic [XLEN-1:0] trap_pc;
   logic            dp_csr_w;
   logic [11:0]     dp_csr_addr;
   logic [XLEN-1:0] dp_csr_wdata;
   logic            csr_w;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            stall;
   logic            pc_redirect;
   logic [XLEN-1:0] redirect_pc;

   // Pipeline plus CSR file side
   modport master (
      output ecall, ebreak, illegal, mret, irq, trap_pc,
      output dp_csr_w, dp_csr_addr, dp_csr_wdata, csr_rdata,
      input  csr_w, csr_addr, csr_wdata, stall, pc_redirect, redirect_pc
   );

   // Trap sequencer side
   modport slave (
      input  ecall, ebreak, illegal, mret, irq, trap_pc,
      input  dp_csr_w, dp_csr_addr, dp_csr_wdata, csr_rdata,
      output csr_w, csr_addr, csr_wdata, stall, pc_redirect, redirect_pc
   );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl
//  Brief    : Machine-mode trap sequencer owning the CSR file write port.
//             Saves mepc/mcause/mstatus and vectors to mtvec on a trap,
//             restores mstatus and returns to mepc on mret, and forwards
//             datapath CSR writes while idle.
//  Revision : 1.0  initial release
// ============================================================================
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}}
) (
   input  logic        clk,
   input  logic        rst,
   trap_ctrl_if.slave  bus
);

   logic [2:0]      r_state;
   logic [2:0]      w_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_cause;
   logic            r_mie_shadow;
   logic [XLEN-1:0] w_status;
   trap_req_t       w_req;
   logic            w_unused;

   // The saved PC is word aligned, so its low bits are never consumed
   assign w_unused = ^r_pc[1:0];

   // Pick the highest-priority request; irq only counts when enabled
   always_comb begin
      w_req = trap_prio(bus.illegal, bus.ebreak, bus.ecall,
                        bus.irq & r_mie_shadow, bus.mret);
   end

   // Next state and all CSR/fetch outputs, decoded from the current state
   always_comb begin
      w_next          = r_state;
      w_status        = bus.csr_rdata;
      bus.csr_w       = 1'b0;
      bus.csr_addr    = bus.dp_csr_addr;
      bus.csr_wdata   = bus.dp_csr_wdata;
      bus.stall       = 1'b1;
      bus.pc_redirect = 1'b0;
      bus.redirect_pc = RESET_VEC;
      case (r_state)
         ST_IDLE: begin
            bus.stall = 1'b0;
            bus.csr_w = bus.dp_csr_w;
            if (w_req.valid) begin
               // The trapping instruction must not commit its CSR write
               bus.csr_w = 1'b0;
               bus.stall = 1'b1;
               w_next    = w_req.is_ret ? ST_RET_STATUS : ST_SAVE_EPC;
            end
         end
         ST_SAVE_EPC: begin
            bus.csr_w     = 1'b1;
            bus.csr_addr  = CSR_MEPC;
            bus.csr_wdata = {r_pc[XLEN-1:2], 2'b00};
            w_next        = ST_SAVE_CAUSE;
         end
         ST_SAVE_CAUSE: begin
            bus.csr_w     = 1'b1;
            bus.csr_addr  = CSR_MCAUSE;
            bus.csr_wdata = r_cause;
            w_next        = ST_SET_STATUS;
         end
         ST_SET_STATUS: begin
            w_status[MSTATUS_MPIE] = bus.csr_rdata[MSTATUS_MIE];
            w_status[MSTATUS_MIE]  = 1'b0;
            bus.csr_w     = 1'b1;
            bus.csr_addr  = CSR_MSTATUS;
            bus.csr_wdata = w_status;
            w_next        = ST_VECTOR;
         end
         ST_VECTOR: begin
            bus.csr_addr    = CSR_MTVEC;
            bus.redirect_pc = {bus.csr_rdata[XLEN-1:2], 2'b00};
            bus.pc_redirect = 1'b1;
            w_next          = ST_IDLE;
         end
         ST_RET_STATUS: begin
            w_status[MSTATUS_MIE]  = bus.csr_rdata[MSTATUS_MPIE];
            w_status[MSTATUS_MPIE] = 1'b1;
            bus.csr_w     = 1'b1;
            bus.csr_addr  = CSR_MSTATUS;
            bus.csr_wdata = w_status;
            w_next        = ST_RET_PC;
         end
         ST_RET_PC: begin
            bus.csr_addr    = CSR_MEPC;
            bus.redirect_pc = bus.csr_rdata;
            bus.pc_redirect = 1'b1;
            w_next          = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      // A reset cycle must not let a half-finished sequence write or jump
      if (rst) begin
         bus.csr_w       = 1'b0;
         bus.pc_redirect = 1'b0;
         bus.redirect_pc = RESET_VEC;
      end
   end

   // State, request latches and the MIE shadow of mstatus
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_pc         <= '0;
         r_cause      <= '0;
         r_mie_shadow <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_req.valid) begin
            r_pc    <= bus.trap_pc;
            r_cause <= XLEN'(w_req.cause);
         end
         if (bus.csr_w && bus.csr_addr == CSR_MSTATUS) begin
            r_mie_shadow <= bus.csr_wdata[MSTATUS_MIE];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trap_ctrl
//  Brief    : Directed self-checking bench for trap_ctrl with a small CSR
//             file model hanging off the sequencer's write port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

   localparam logic [11:0] A_MSTATUS = 12'h000;
   localparam logic [11:0] A_MTVEC   = 12'h005;
   localparam logic [11:0] A_MEPC    = 12'h041;
   localparam logic [11:0] A_MCAUSE  = 12'h042;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [31:0] m_mstatus = 32'd0;
   logic [31:0] m_mtvec   = 32'd0;
   logic [31:0] m_mepc    = 32'd0;
   logic [31:0] m_mcause  = 32'd0;

   trap_ctrl_if #(.XLEN(32)) bus ();

   trap_ctrl #(.XLEN(32), .RESET_VEC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // CSR file model: combinational read, write on the clock edge
   always_comb begin
      bus.csr_rdata = 32'd0;
      case (bus.csr_addr)
         A_MSTATUS: bus.csr_rdata = m_mstatus;
         A_MTVEC:   bus.csr_rdata = m_mtvec;
         A_MEPC:    bus.csr_rdata = m_mepc;
         A_MCAUSE:  bus.csr_rdata = m_mcause;
         default:   bus.csr_rdata = 32'd0;
      endcase
   end

   // CSR file model write port
   always @(posedge clk) begin
      if (bus.csr_w) begin
         case (bus.csr_addr)
            A_MSTATUS: m_mstatus <= bus.csr_wdata;
            A_MTVEC:   m_mtvec   <= bus.csr_wdata;
            A_MEPC:    m_mepc    <= bus.csr_wdata;
            A_MCAUSE:  m_mcause  <= bus.csr_wdata;
            default:   ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Check one cycle's outputs mid-cycle, then advance to just after the edge
   task automatic cyc(input string tag, input logic s, input logic w,
                      input logic [11:0] a, input logic [31:0] d,
                      input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      check({tag, ".stall"}, 32'(bus.stall), 32'(s));
      check({tag, ".csr_w"}, 32'(bus.csr_w), 32'(w));
      if (w) begin
         check({tag, ".addr"}, 32'(bus.csr_addr), 32'(a));
         check({tag, ".wdata"}, bus.csr_wdata, d);
      end
      check({tag, ".redir"}, 32'(bus.pc_redirect), 32'(rd));
      check({tag, ".rpc"}, bus.redirect_pc, rpc);
      @(posedge clk);
      #1;
   endtask

   task automatic dp_write(input string tag, input logic [11:0] a, input logic [31:0] d);
      bus.dp_csr_w     = 1'b1;
      bus.dp_csr_addr  = a;
      bus.dp_csr_wdata = d;
      cyc(tag, 1'b0, 1'b1, a, d, 1'b0, 32'd0);
      bus.dp_csr_w     = 1'b0;
   endtask

   initial begin
      bus.ecall = 0; bus.ebreak = 0; bus.illegal = 0; bus.mret = 0; bus.irq = 0;
      bus.trap_pc = 32'd0; bus.dp_csr_w = 0; bus.dp_csr_addr = 12'd0; bus.dp_csr_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cyc("reset", 0, 0, 12'd0, 32'd0, 0, 32'd0);

      // Set up mtvec and mstatus through the idle passthrough
      dp_write("init_mtvec", A_MTVEC, 32'h100);
      dp_write("init_mstatus", A_MSTATUS, 32'h8);

      // ecall trap entry with a dropped datapath write during SAVE_CAUSE
      bus.ecall = 1; bus.trap_pc = 32'h24;
      cyc("ecall0", 1, 0, 12'd0, 32'd0, 0, 32'd0);
      bus.ecall = 0;
      cyc("ecall1", 1, 1, A_MEPC, 32'h24, 0, 32'd0);
      bus.dp_csr_w = 1; bus.dp_csr_addr = A_MEPC; bus.dp_csr_wdata = 32'hDEAD_BEEF;
      cyc("ecall2", 1, 1, A_MCAUSE, 32'd11, 0, 32'd0);
      bus.dp_csr_w = 0;
      cyc("ecall3", 1, 1, A_MSTATUS, 32'h80, 0, 32'd0);
      cyc("ecall4", 1, 0, 12'd0, 32'd0, 1, 32'h100);
      cyc("ecall5", 0, 0, 12'd0, 32'd0, 0, 32'd0);
      check("ecall.mepc", m_mepc, 32'h24);
      check("ecall.mcause", m_mcause, 32'd11);
      check("ecall.mstatus", m_mstatus, 32'h80);

      // mret restores MIE from MPIE and returns to mepc
      bus.mret = 1;
      cyc("mret0", 1, 0, 12'd0, 32'd0, 0, 32'd0);
      bus.mret = 0;
      cyc("mret1", 1, 1, A_MSTATUS, 32'h88, 0, 32'd0);
      cyc("mret2", 1, 0, 12'd0, 32'd0, 1, 32'h24);
      cyc("mret3", 0, 0, 12'd0, 32'd0, 0, 32'd0);
      check("mret.mstatus", m_mstatus, 32'h88);

      // Simultaneous illegal/ebreak/ecall: illegal wins, one sequence only
      bus.illegal = 1; bus.ebreak = 1; bus.ecall = 1; bus.trap_pc = 32'h40;
      cyc("prio0", 1, 0, 12'd0, 32'd0, 0, 32'd0);
      bus.illegal = 0; bus.ebreak = 0; bus.ecall = 0;
      cyc("prio1", 1, 1, A_MEPC, 32'h40, 0, 32'd0);
      cyc("prio2", 1, 1, A_MCAUSE, 32'd2, 0, 32'd0);
      cyc("prio3", 1, 1, A_MSTATUS, 32'h80, 0, 32'd0);
      cyc("prio4", 1, 0, 12'd0, 32'd0, 1, 32'h100);
      cyc("prio5", 0, 0, 12'd0, 32'd0, 0, 32'd0);
      cyc("prio6", 0, 0, 12'd0, 32'd0, 0, 32'd0);
      check("prio.mcause", m_mcause, 32'd2);

      // irq is ignored while MIE is clear
      dp_write("irq_mie0", A_MSTATUS, 32'h0);
      bus.irq = 1; bus.trap_pc = 32'h60;
      for (int i = 0; i < 3; i++) cyc("irq_masked", 0, 0, 12'd0, 32'd0, 0, 32'd0);
      // Enabling MIE through the datapath lets the held irq in next cycle
      dp_write("irq_mie1", A_MSTATUS, 32'h8);
      cyc("irq0", 1, 0, 12'd0, 32'd0, 0, 32'd0);
      bus.irq = 0;
      cyc("irq1", 1, 1, A_MEPC, 32'h60, 0, 32'd0);
      cyc("irq2", 1, 1, A_MCAUSE, 32'h8000_000B, 0, 32'd0);
      cyc("irq3", 1, 1, A_MSTATUS, 32'h80, 0, 32'd0);
      cyc("irq4", 1, 0, 12'd0, 32'd0, 1, 32'h100);
      cyc("irq5", 0, 0, 12'd0, 32'd0, 0, 32'd0);
      check("irq.mcause", m_mcause, 32'h8000_000B);

      // Reset in SAVE_CAUSE abandons the sequence without further writes
      bus.ecall = 1; bus.trap_pc = 32'h80;
      cyc("rmid0", 1, 0, 12'd0, 32'd0, 0, 32'd0);
      bus.ecall = 0;
      cyc("rmid1", 1, 1, A_MEPC, 32'h80, 0, 32'd0);
      rst = 1;
      cyc("rmid2", 1, 0, 12'd0, 32'd0, 0, 32'd0);
      rst = 0;
      for (int i = 0; i < 3; i++) cyc("rmid_idle", 0, 0, 12'd0, 32'd0, 0, 32'd0);
      check("rmid.mcause", m_mcause, 32'h8000_000B);
      check("rmid.mstatus", m_mstatus, 32'h80);
      check("rmid.mepc", m_mepc, 32'h80);

      // Idle passthrough of an mtvec write
      dp_write("pass_mtvec", A_MTVEC, 32'h200);
      @(negedge clk);
      check("pass.mtvec", m_mtvec, 32'h200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
